sega_pad_responder: RTL and testbench

SEGA_PAD_RESPONDER -- requirements
Module: sega_pad_responder

---
 rtl/sega_pad_pkg.sv | 38 +++
 rtl/pad_sel_sync.sv | 30 +++
 rtl/sega_pad_responder.sv | 128 ++++++++++++
 tb/tb_sega_pad_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sega_pad_pkg.sv
// Shared constants for the Sega pad responder.
// Button bits, pad pin bits and protocol phase encodings.
package sega_pad_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_Z     = 10;
    localparam int BTN_MODE  = 11;

    localparam int PAD_D1 = 0;
    localparam int PAD_D2 = 1;
    localparam int PAD_D3 = 2;
    localparam int PAD_D4 = 3;
    localparam int PAD_D6 = 4;
    localparam int PAD_D9 = 5;

    localparam logic [5:0] PAD_RELEASED = 6'b111111;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_1    = 3'd1,
        PH_2    = 3'd2,
        PH_3    = 3'd3,
        PH_4    = 3'd4,
        PH_ID   = 3'd5,
        PH_EXT  = 3'd6,
        PH_LAST = 3'd7
    } phase_t;

endpackage

// File: rtl/pad_sel_sync.sv
// Two-flop synchronizer for the console select line.
// Emits one-cycle rise/fall pulses on the synchronized value.
module pad_sel_sync (
    input  logic clock,
    input  logic reset,
    input  logic sel,
    output logic sel_sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta     <= 1'b1;
            sel_sync <= 1'b1;
            prev     <= 1'b1;
        end else begin
            meta     <= sel;
            sel_sync <= meta;
            prev     <= sel_sync;
        end
    end

    assign rise = sel_sync & ~prev;
    assign fall = ~sel_sync & prev;

endmodule

// File: rtl/sega_pad_responder.sv
// Sega Genesis pad emulator answering the console select line.
// Define SEGA_SIX_BUTTON_EN for the 6-button protocol (X/Y/Z/Mode + timeout).
module sega_pad_responder
    import sega_pad_pkg::*;
#(
    parameter int unsigned TIMEOUT = 37500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] btn,
    input  logic        sel,
    output logic [5:0]  pad,
    output logic [2:0]  phase
);

    logic       sel_s;
    logic       sel_rise;
    logic       sel_fall;
    logic       sel_edge;
    logic [2:0] phase_nxt;
    logic [5:0] pad_nxt;

    pad_sel_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .sel      (sel),
        .sel_sync (sel_s),
        .rise     (sel_rise),
        .fall     (sel_fall)
    );

    assign sel_edge = sel_rise | sel_fall;

`ifdef SEGA_SIX_BUTTON_EN
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] idle_cnt;
    logic          timeout_hit;

    // Count saturates at LAST so the idle phase is held until the next edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (sel_edge) begin
            idle_cnt <= '0;
        end else if (idle_cnt != LAST) begin
            idle_cnt <= idle_cnt + CW'(1);
        end
    end

    assign timeout_hit = (idle_cnt == LAST) ||
                         (idle_cnt == LAST - CW'(1));
`else
    localparam int unsigned unused_timeout = TIMEOUT;
    logic unused_btn;
    assign unused_btn = ^{btn[BTN_X], btn[BTN_Y],
                          btn[BTN_Z], btn[BTN_MODE]};
`endif

    always_comb begin
        phase_nxt = phase;
        if (sel_edge) begin
            if (phase != PH_LAST) begin
                phase_nxt = phase + 3'd1;
            end
`ifdef SEGA_SIX_BUTTON_EN
        end else if (timeout_hit) begin
            phase_nxt = PH_IDLE;
`endif
        end
    end

    // Pad is built from the phase being entered so sel and phase agree.
    always_comb begin
        pad_nxt = PAD_RELEASED;
        if (sel_s) begin
            pad_nxt[PAD_D1] = ~btn[BTN_UP];
            pad_nxt[PAD_D2] = ~btn[BTN_DOWN];
            pad_nxt[PAD_D3] = ~btn[BTN_LEFT];
            pad_nxt[PAD_D4] = ~btn[BTN_RIGHT];
            pad_nxt[PAD_D6] = ~btn[BTN_B];
            pad_nxt[PAD_D9] = ~btn[BTN_C];
        end else begin
            pad_nxt[PAD_D1] = ~btn[BTN_UP];
            pad_nxt[PAD_D2] = ~btn[BTN_DOWN];
            pad_nxt[PAD_D3] = 1'b0;
            pad_nxt[PAD_D4] = 1'b0;
            pad_nxt[PAD_D6] = ~btn[BTN_A];
            pad_nxt[PAD_D9] = ~btn[BTN_START];
        end
`ifdef SEGA_SIX_BUTTON_EN
        unique case (1'b1)
            sel_s && (phase_nxt == PH_EXT): begin
                pad_nxt[PAD_D1] = ~btn[BTN_Z];
                pad_nxt[PAD_D2] = ~btn[BTN_Y];
                pad_nxt[PAD_D3] = ~btn[BTN_X];
                pad_nxt[PAD_D4] = ~btn[BTN_MODE];
            end
            !sel_s && (phase_nxt == PH_ID): begin
                pad_nxt[PAD_D1] = 1'b0;
                pad_nxt[PAD_D2] = 1'b0;
                pad_nxt[PAD_D3] = 1'b0;
                pad_nxt[PAD_D4] = 1'b0;
            end
            !sel_s && (phase_nxt == PH_LAST): begin
                pad_nxt[PAD_D1] = 1'b1;
                pad_nxt[PAD_D2] = 1'b1;
                pad_nxt[PAD_D3] = 1'b1;
                pad_nxt[PAD_D4] = 1'b1;
            end
            default: begin
            end
        endcase
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase <= PH_IDLE;
            pad   <= PAD_RELEASED;
        end else begin
            phase <= phase_nxt;
            pad   <= pad_nxt;
        end
    end

endmodule

// File: tb/tb_sega_pad_responder.sv
// Directed bench for sega_pad_responder.
// Six-button scenarios are built only with SEGA_SIX_BUTTON_EN.
`timescale 1ns/1ps
module tb_sega_pad_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] btn;
    logic        sel;
    logic [5:0]  pad;
    logic [2:0]  phase;

    int total = 0;
    int bad   = 0;

    always #20 clock = ~clock;

    sega_pad_responder dut (
        .clock (clock),
        .reset (reset),
        .btn   (btn),
        .sel   (sel),
        .pad   (pad),
        .phase (phase)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        sel   = 1'b1;
        btn   = 12'h000;
        tick(2);
        @(negedge clock);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic toggle(input int gap);
        sel = ~sel;
        tick(gap);
    endtask

    task automatic test_reset;
        #7;
        total++;
        if (pad !== 6'b111111) begin
            bad++;
            $display("FAIL reset_pad got=%b want=111111", pad);
        end
        total++;
        if (phase !== 3'd0) begin
            bad++;
            $display("FAIL reset_phase got=%0d want=0", phase);
        end
        @(negedge clock);
        reset = 1'b0;
        tick(3);
        total++;
        if (pad !== 6'b111111 || phase !== 3'd0) begin
            bad++;
            $display("FAIL idle_after_reset got=%b/%0d want=111111/0",
                     pad, phase);
        end
        btn = 12'hFFF;
        tick(3);
        total++;
        if (pad !== 6'b000000) begin
            bad++;
            $display("FAIL all_pressed got=%b want=000000", pad);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        total++;
        if (pad !== 6'b111111 || phase !== 3'd0) begin
            bad++;
            $display("FAIL async_reset got=%b/%0d want=111111/0",
                     pad, phase);
        end
        @(negedge clock);
        reset = 1'b0;
        btn = 12'h000;
        tick(1);
    endtask

    task automatic test_sel_high;
        logic [11:0] vb [8];
        logic [5:0]  vp [8];
        vb = '{12'h001, 12'h002, 12'h004, 12'h008,
               12'h020, 12'h040, 12'h090, 12'h00F};
        vp = '{6'b111110, 6'b111101, 6'b111011, 6'b110111,
               6'b101111, 6'b011111, 6'b111111, 6'b110000};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            btn = vb[i];
            tick(3);
            total++;
            if (pad !== vp[i]) begin
                bad++;
                $display("FAIL sel_high btn=%h got=%b want=%b",
                         vb[i], pad, vp[i]);
            end
        end
    endtask

    task automatic test_sel_low;
        do_reset();
        btn = 12'h090;
        tick(2);
        sel = 1'b0;
        tick(2);
        total++;
        if (pad !== 6'b111111 || phase !== 3'd0) begin
            bad++;
            $display("FAIL sync_latency got=%b/%0d want=111111/0",
                     pad, phase);
        end
        tick(1);
        total++;
        if (pad !== 6'b000011) begin
            bad++;
            $display("FAIL sel_low_pad got=%b want=000011", pad);
        end
        total++;
        if (phase !== 3'd1) begin
            bad++;
            $display("FAIL sel_low_phase got=%0d want=1", phase);
        end
        btn = 12'h093;
        tick(1);
        total++;
        if (pad !== 6'b000000) begin
            bad++;
            $display("FAIL sel_low_updn got=%b want=000000", pad);
        end
        sel = 1'b1;
        tick(3);
        total++;
        if (pad !== 6'b111100 || phase !== 3'd2) begin
            bad++;
            $display("FAIL sel_rise got=%b/%0d want=111100/2",
                     pad, phase);
        end
    endtask

    task automatic test_reset_abort;
        do_reset();
        btn = 12'h090;
        for (int i = 0; i < 5; i++) toggle(10);
        total++;
        if (phase !== 3'd5) begin
            bad++;
            $display("FAIL abort_setup got=%0d want=5", phase);
        end
        @(negedge clock);
        reset = 1'b1;
        sel   = 1'b1;
        #1;
        total++;
        if (pad !== 6'b111111 || phase !== 3'd0) begin
            bad++;
            $display("FAIL abort_reset got=%b/%0d want=111111/0",
                     pad, phase);
        end
        tick(2);
        @(negedge clock);
        reset = 1'b0;
        tick(5);
        total++;
        if (phase !== 3'd0) begin
            bad++;
            $display("FAIL abort_idle got=%0d want=0", phase);
        end
        sel = 1'b0;
        tick(3);
        total++;
        if (pad !== 6'b000011 || phase !== 3'd1) begin
            bad++;
            $display("FAIL abort_fall got=%b/%0d want=000011/1",
                     pad, phase);
        end
    endtask

`ifdef SEGA_SIX_BUTTON_EN
    task automatic test_six_button;
        logic [5:0] ep;
        do_reset();
        btn = 12'h400;
        tick(3);
        for (int i = 1; i <= 7; i++) begin
            toggle(250);
            case (i)
                1, 3:    ep = 6'b110011;
                5:       ep = 6'b110000;
                6:       ep = 6'b111110;
                default: ep = 6'b111111;
            endcase
            total++;
            if (phase !== 3'(i) || pad !== ep) begin
                bad++;
                $display("FAIL six_edge%0d got=%b/%0d want=%b/%0d",
                         i, pad, phase, ep, i);
            end
            if (i == 6) begin
                btn = 12'hB00;
                tick(2);
                total++;
                if (pad !== 6'b110001) begin
                    bad++;
                    $display("FAIL six_xym got=%b want=110001", pad);
                end
                btn = 12'h400;
                tick(2);
            end
        end
        btn = 12'h402;
        toggle(250);
        total++;
        if (phase !== 3'd7 || pad !== 6'b111101) begin
            bad++;
            $display("FAIL six_saturate got=%b/%0d want=111101/7",
                     pad, phase);
        end
    endtask

    task automatic test_timeout;
        int n;
        do_reset();
        btn = 12'h090;
        tick(3);
        toggle(10);
        toggle(10);
        sel = ~sel;
        n = 0;
        while (phase !== 3'd3 && n < 10) begin
            tick(1);
            n++;
        end
        total++;
        if (phase !== 3'd3) begin
            bad++;
            $display("FAIL to_arm got=%0d want=3", phase);
        end
        tick(37498);
        total++;
        if (phase !== 3'd3) begin
            bad++;
            $display("FAIL to_early got=%0d want=3", phase);
        end
        tick(1);
        total++;
        if (phase !== 3'd0 || pad !== 6'b000011) begin
            bad++;
            $display("FAIL to_fire got=%b/%0d want=000011/0",
                     pad, phase);
        end
        tick(100);
        total++;
        if (phase !== 3'd0) begin
            bad++;
            $display("FAIL to_hold got=%0d want=0", phase);
        end
        sel = 1'b1;
        n = 0;
        while (phase !== 3'd1 && n < 10) begin
            tick(1);
            n++;
        end
        total++;
        if (phase !== 3'd1 || pad !== 6'b111111) begin
            bad++;
            $display("FAIL to_restart got=%b/%0d want=111111/1",
                     pad, phase);
        end
        tick(37496);
        sel = 1'b0;
        tick(2);
        total++;
        if (phase !== 3'd1) begin
            bad++;
            $display("FAIL to_pre_tie got=%0d want=1", phase);
        end
        tick(1);
        total++;
        if (phase !== 3'd2) begin
            bad++;
            $display("FAIL to_tie got=%0d want=2", phase);
        end
        tick(3);
        total++;
        if (phase !== 3'd2) begin
            bad++;
            $display("FAIL to_tie_hold got=%0d want=2", phase);
        end
    endtask
`else
    task automatic test_three_button;
        logic [5:0] ep;
        logic [2:0] eph;
        do_reset();
        btn = 12'hF00;
        tick(3);
        total++;
        if (pad !== 6'b111111) begin
            bad++;
            $display("FAIL three_idle got=%b want=111111", pad);
        end
        for (int i = 1; i <= 8; i++) begin
            toggle(10);
            ep  = sel ? 6'b111111 : 6'b110011;
            eph = (i > 7) ? 3'd7 : 3'(i);
            total++;
            if (phase !== eph || pad !== ep) begin
                bad++;
                $display("FAIL three_edge%0d got=%b/%0d want=%b/%0d",
                         i, pad, phase, ep, eph);
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        sel   = 1'b1;
        btn   = 12'h000;
        test_reset();
        test_sel_high();
        test_sel_low();
        test_reset_abort();
`ifdef SEGA_SIX_BUTTON_EN
        test_six_button();
        test_timeout();
`else
        test_three_button();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
